// File: rtl/instr_mem_port.sv
// Instruction memory port: byte-wide program store read back as 32-bit little-endian words.
// Latency: READ sampled at edge N -> READDATA valid, BUSYWAIT low after edge N+3 (after N on a prefetch hit).
// Backpressure: BUSYWAIT stalls the CPU while a fetch is pending; loads are accepted only in IDLE.
// Optional feature macro: INSTR_MEM_PREFETCH_EN adds a one-word next-line prefetch buffer.
// Ports: CLK, RESET (async active-low); READ/ADDRESS in, READDATA/BUSYWAIT out (fetch side);
//        LOAD_EN/LOAD_ADDR/LOAD_DATA in (byte-wide program load side).
module instr_mem_port #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ,
    input  logic [31:0]          ADDRESS,
    output logic [31:0]          READDATA,
    output logic                 BUSYWAIT,
    input  logic                 LOAD_EN,
    input  logic [ADDR_BITS-1:0] LOAD_ADDR,
    input  logic [7:0]           LOAD_DATA
);
    localparam int WB    = ADDR_BITS - 2;
    localparam int DEPTH = 1 << ADDR_BITS;

`ifdef INSTR_MEM_PREFETCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RESPOND = 2'd2, PREFETCH = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RESPOND = 2'd2} state_t;
`endif

    state_t        state_q, state_d;
    logic [WB-1:0] word_q, word_d;      // latched word index of the request
    logic [1:0]    cnt_q, cnt_d;        // byte counter within the word
    logic [23:0]   asm_q, asm_d;        // bytes 0..2; byte 3 goes straight to READDATA
    logic [31:0]   rdata_q, rdata_d;
    logic [7:0]    mem_q [DEPTH];

    logic [WB-1:0] req_word;
    logic          load_we;
    logic [7:0]    byte0_now;
    logic [7:0]    fetch_byte;
    logic          unused_addr_bits;

    assign req_word         = ADDRESS[ADDR_BITS-1:2];
    assign unused_addr_bits = ^{ADDRESS[31:ADDR_BITS], ADDRESS[1:0]};
    assign load_we          = LOAD_EN && (state_q == IDLE);
    // A fetch starting on the same edge as a load must see the byte being written.
    assign byte0_now  = (load_we && (LOAD_ADDR == {req_word, 2'b00})) ? LOAD_DATA
                                                                       : mem_q[{req_word, 2'b00}];
    // Word index and byte lane are concatenated, so the top word never wraps internally.
    assign fetch_byte = mem_q[{word_q, cnt_q}];

`ifdef INSTR_MEM_PREFETCH_EN
    logic [31:0]   pf_buf_q, pf_buf_d;
    logic [WB-1:0] pf_tag_q, pf_tag_d;
    logic          pf_vld_q, pf_vld_d;
    logic [WB-1:0] pf_word;
    logic [7:0]    pf_byte;
    logic          load_hits_buf;
    logic          pf_hit;

    assign pf_word       = word_q + {{(WB-1){1'b0}}, 1'b1};
    assign pf_byte       = mem_q[{pf_word, cnt_q}];
    assign load_hits_buf = load_we && (LOAD_ADDR[ADDR_BITS-1:2] == pf_tag_q);
    // A load into the buffered word on the same edge makes the buffer stale: treat as a miss.
    assign pf_hit        = pf_vld_q && !load_hits_buf && (pf_tag_q == req_word);
`endif

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;
`ifdef INSTR_MEM_PREFETCH_EN
        pf_buf_d = pf_buf_q;
        pf_tag_d = pf_tag_q;
        pf_vld_d = pf_vld_q && !load_hits_buf;
`endif
        case (state_q)
            IDLE: begin
                if (READ) begin
                    word_d     = req_word;
                    asm_d[7:0] = byte0_now;
                    cnt_d      = 2'd1;
                    state_d    = FETCH;
`ifdef INSTR_MEM_PREFETCH_EN
                    if (pf_hit) begin
                        rdata_d = pf_buf_q;
                        cnt_d   = 2'd0;
                        state_d = RESPOND;
                    end
`endif
                end
            end
            FETCH: begin
                if (!READ) begin
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else if (cnt_q == 2'd3) begin
                    rdata_d = {fetch_byte, asm_q};
                    cnt_d   = 2'd0;
                    state_d = RESPOND;
                end else begin
                    case (cnt_q)
                        2'd1:    asm_d[15:8]  = fetch_byte;
                        2'd2:    asm_d[23:16] = fetch_byte;
                        default: asm_d[7:0]   = fetch_byte;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESPOND: begin
                state_d = IDLE;
`ifdef INSTR_MEM_PREFETCH_EN
                // CPU has let go: use the idle time to pull in the next sequential word.
                if (!READ) begin
                    cnt_d    = 2'd0;
                    pf_vld_d = 1'b0;
                    state_d  = PREFETCH;
                end
`endif
            end
`ifdef INSTR_MEM_PREFETCH_EN
            PREFETCH: begin
                if (READ) begin
                    pf_vld_d   = 1'b0;
                    word_d     = req_word;
                    asm_d[7:0] = byte0_now;
                    cnt_d      = 2'd1;
                    state_d    = FETCH;
                end else begin
                    case (cnt_q)
                        2'd0:    pf_buf_d[7:0]   = pf_byte;
                        2'd1:    pf_buf_d[15:8]  = pf_byte;
                        2'd2:    pf_buf_d[23:16] = pf_byte;
                        default: pf_buf_d[31:24] = pf_byte;
                    endcase
                    if (cnt_q == 2'd3) begin
                        pf_tag_d = pf_word;
                        pf_vld_d = 1'b1;
                        cnt_d    = 2'd0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= 2'd0;
            asm_q   <= 24'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef INSTR_MEM_PREFETCH_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pf_buf_q <= 32'h0;
            pf_tag_q <= '0;
            pf_vld_q <= 1'b0;
        end else begin
            pf_buf_q <= pf_buf_d;
            pf_tag_q <= pf_tag_d;
            pf_vld_q <= pf_vld_d;
        end
    end
`endif

    // Program store is deliberately not reset: contents survive a CPU reset.
    always_ff @(posedge CLK) begin
        if (load_we) begin
            mem_q[LOAD_ADDR] <= LOAD_DATA;
        end
    end

    assign READDATA = rdata_q;
    assign BUSYWAIT = RESET && READ && (state_q != RESPOND);

endmodule
